wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 85 ++++++++
 tb/tb_wb_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: single-cycle writeback/commit stage with exception/ertn/refetch/idle flushes, TLB strobes and RUN/IDLE wait-for-interrupt FSM
module wb_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_to_ws_valid,
  input  logic [217:0] ms_to_ws_bus,
  input  logic         has_int,
  output logic         ws_allowin,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic [37:0]  ws_to_ds_forward_bus,
  output logic         csr_we,
  output logic [13:0]  csr_idx,
  output logic [31:0]  csr_wdata,
  output logic         excp_flush,
  output logic         ertn_flush,
  output logic         refetch_flush,
  output logic         idle_flush,
  output logic [15:0]  wb_excp_num,
  output logic [31:0]  wb_era,
  output logic [31:0]  wb_badv,
  output logic         tlbsrch_en,
  output logic         tlbrd_en,
  output logic         tlbwr_en,
  output logic         tlbfill_en,
  output logic         invtlb_en,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_we,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);
  typedef enum logic {RUN, IDLE} state_t;
  state_t state;
  logic ws_valid;
  logic [217:0] bus;
  logic commit, ok, any_flush;
  logic [31:0] pc, result;
  logic [4:0] dest;
  logic gr_we, excp;
  logic unused_bus;
  assign pc = bus[31:0];
  assign result = bus[63:32];
  assign dest = bus[68:64];
  assign gr_we = bus[69];
  assign excp = bus[70];
  assign unused_bus = ^{bus[136:135], bus[175:170], bus[216:181]};
  assign commit = ws_valid && state == RUN;
  assign ok = commit && !excp;
  assign rf_we = ok && gr_we;
  assign rf_waddr = dest;
  assign rf_wdata = result;
  assign ws_to_ds_forward_bus = {ws_valid && gr_we && !excp && dest != 5'd0, dest, result};
  assign csr_we = ok && bus[118];
  assign csr_idx = bus[117:104];
  assign csr_wdata = bus[103:72];
  assign excp_flush = commit && excp;
  assign ertn_flush = ok && bus[71];
  assign refetch_flush = ok && bus[178];
  assign idle_flush = ok && bus[217];
  assign wb_excp_num = bus[134:119];
  assign wb_era = pc;
  assign wb_badv = bus[168:137];
  assign tlbsrch_en = ok && bus[169];
  assign tlbwr_en = ok && bus[176];
  assign tlbfill_en = ok && bus[177];
  assign tlbrd_en = ok && bus[179];
  assign invtlb_en = ok && bus[180];
  assign any_flush = excp_flush || ertn_flush || refetch_flush || idle_flush;
  assign ws_allowin = state == RUN && !any_flush;
  assign debug_wb_pc = pc;
  assign debug_wb_rf_we = {4{rf_we}};
  assign debug_wb_rf_wnum = dest;
  assign debug_wb_rf_wdata = result;
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      state <= RUN;
    end else begin
      ws_valid <= ws_allowin && ms_to_ws_valid;
      state <= state == RUN ? (idle_flush ? IDLE : RUN) : (has_int ? RUN : IDLE);
    end
    if (ms_to_ws_valid && ws_allowin) bus <= ms_to_ws_bus;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage
module tb_wb_stage;
  logic clk = 0, reset = 1, ms_to_ws_valid = 0, has_int = 0;
  logic [217:0] ms_to_ws_bus = '0;
  logic ws_allowin, rf_we, csr_we, excp_flush, ertn_flush, refetch_flush, idle_flush;
  logic tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_wdata, wb_era, wb_badv, debug_wb_pc, debug_wb_rf_wdata;
  logic [37:0] ws_to_ds_forward_bus;
  logic [13:0] csr_idx;
  logic [15:0] wb_excp_num;
  logic [3:0] debug_wb_rf_we;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic rf_we, csr_we, excp_flush, ertn_flush, refetch_flush, idle_flush, tlbwr_en, fwd;
    logic [4:0] waddr;
    logic [31:0] wdata, pc, va;
    logic [15:0] ecode;
  } exp_t;
  exp_t sb[$];
  wb_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .has_int(has_int), .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ws_to_ds_forward_bus(ws_to_ds_forward_bus), .csr_we(csr_we),
    .csr_idx(csr_idx), .csr_wdata(csr_wdata), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .refetch_flush(refetch_flush), .idle_flush(idle_flush), .wb_excp_num(wb_excp_num),
    .wb_era(wb_era), .wb_badv(wb_badv), .tlbsrch_en(tlbsrch_en), .tlbrd_en(tlbrd_en),
    .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en), .invtlb_en(invtlb_en),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [217:0] mk(input logic [31:0] pc, res, input logic [4:0] dest,
      input logic gr_we, excp, ertn, cwe, tlbwr, refetch, idle, input logic [15:0] ecode, input logic [31:0] va);
    logic [217:0] b = '0;
    b[31:0] = pc; b[63:32] = res; b[68:64] = dest; b[69] = gr_we; b[70] = excp; b[71] = ertn;
    b[103:72] = ~res; b[117:104] = 14'h6; b[118] = cwe; b[134:119] = ecode; b[168:137] = va;
    b[176] = tlbwr; b[178] = refetch; b[217] = idle;
    return b;
  endfunction
  task automatic send(input logic [217:0] b);
    exp_t e, g;
    logic x;
    x = b[70];
    e.rf_we = b[69] && !x; e.csr_we = b[118] && !x; e.excp_flush = x;
    e.ertn_flush = b[71] && !x; e.refetch_flush = b[178] && !x; e.idle_flush = b[217] && !x;
    e.tlbwr_en = b[176] && !x; e.fwd = b[69] && !x && b[68:64] != 0;
    e.waddr = b[68:64]; e.wdata = b[63:32]; e.pc = b[31:0]; e.va = b[168:137]; e.ecode = b[134:119];
    chk("allowin_at_send", ws_allowin, 1);
    ms_to_ws_valid = 1; ms_to_ws_bus = b;
    sb.push_back(e);
    @(negedge clk);
    ms_to_ws_valid = 0;
    g = sb.pop_front();
    chk("rf_we", rf_we, g.rf_we);
    chk("dbg_rf_we", debug_wb_rf_we, {4{g.rf_we}});
    chk("csr_we", csr_we, g.csr_we);
    chk("excp_flush", excp_flush, g.excp_flush);
    chk("ertn_flush", ertn_flush, g.ertn_flush);
    chk("refetch_flush", refetch_flush, g.refetch_flush);
    chk("idle_flush", idle_flush, g.idle_flush);
    chk("tlbwr_en", tlbwr_en, g.tlbwr_en);
    chk("fwd", ws_to_ds_forward_bus, {g.fwd, g.waddr, g.wdata});
    chk("dbg_pc", debug_wb_pc, g.pc);
    if (g.rf_we) chk("rf_waddr_data", {rf_waddr, rf_wdata}, {g.waddr, g.wdata});
    if (g.csr_we) chk("csr_port", {csr_idx, csr_wdata}, {14'h6, ~g.wdata});
    if (g.excp_flush) chk("excp_info", {wb_excp_num, wb_era, wb_badv}, {g.ecode, g.pc, g.va});
    chk("allowin_flush", ws_allowin, !(g.excp_flush | g.ertn_flush | g.refetch_flush | g.idle_flush));
  endtask
  task automatic quiet(input string tag);
    @(negedge clk);
    chk(tag, {rf_we, csr_we, excp_flush, ertn_flush, refetch_flush, idle_flush, tlbwr_en, ws_to_ds_forward_bus[37]}, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("reset_allowin", ws_allowin, 1);
    chk("reset_outs", {rf_we, csr_we, excp_flush, ertn_flush, refetch_flush, idle_flush, tlbwr_en, tlbsrch_en, tlbrd_en, tlbfill_en, invtlb_en}, 0);
    send(mk(32'h1c000000, 32'h12345678, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    send(mk(32'h1c000004, 32'hcafef00d, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    send(mk(32'h1c000010, 32'h0, 7, 1, 1, 0, 1, 0, 0, 0, 16'h0040, 32'h80000003));
    quiet("excp_pulse");
    for (int i = 0; i < 8; i++)
      send(mk(32'h1c001000 + 4 * i, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, 0));
    send(mk(32'h1c002000, 32'h1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    quiet("tlbwr_pulse");
    send(mk(32'h1c002004, 32'h1, 3, 0, 1, 0, 0, 1, 0, 0, 16'h3f, 32'h0));
    quiet("tlbwr_excp_after");
    send(mk(32'h1c003000, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    ms_to_ws_valid = 1;
    ms_to_ws_bus = mk(32'h1c003004, 32'hbbbb, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet("ertn_b_dropped");
    ms_to_ws_valid = 0;
    send(mk(32'h1c004000, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    quiet("refetch_pulse");
    send(mk(32'h1c005000, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    ms_to_ws_valid = 1;
    ms_to_ws_bus = mk(32'h1c005004, 32'h77, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      quiet("idle_quiet");
      chk("idle_allowin", ws_allowin, 0);
    end
    ms_to_ws_valid = 0;
    has_int = 1;
    @(negedge clk);
    has_int = 0;
    chk("wake_allowin", ws_allowin, 1);
    send(mk(32'h1c006000, 32'h55aa55aa, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    send(mk(32'h1c007000, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    quiet("idle2_quiet");
    chk("idle2_allowin", ws_allowin, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("reset_idle_allowin", ws_allowin, 1);
    chk("reset_idle_rf_we", rf_we, 0);
    send(mk(32'h1c008000, 32'h0badc0de, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
